// File: rtl/tmr1_peripheral_pkg.sv
// -----------------------------------------------------------------------------
// tmr1_peripheral_pkg
//   Shared constants and types for the Timer1 external-peripheral responder:
//   file-address defaults for TMR1L/TMR1H/T1CON, bus widths, the T1CON field
//   layout and the prescaler mask helper.
// -----------------------------------------------------------------------------
package tmr1_peripheral_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 8;

  // File addresses of the Timer1 registers (bank 0).
  localparam logic [ADDR_W-1:0] TMR1L_ADDR_DEF = 9'h00E;
  localparam logic [ADDR_W-1:0] TMR1H_ADDR_DEF = 9'h00F;
  localparam logic [ADDR_W-1:0] T1CON_ADDR_DEF = 9'h010;

  typedef enum logic [1:0] {
    PS_1_1 = 2'd0,
    PS_1_2 = 2'd1,
    PS_1_4 = 2'd2,
    PS_1_8 = 2'd3
  } t1ckps_e;

  // T1CON, MSB first.
  typedef struct packed {
    logic       t1ginv;   // [7] gate polarity
    logic       tmr1ge;   // [6] gate enable
    t1ckps_e    t1ckps;   // [5:4] prescale select
    logic [1:0] spare;    // [3:2] storage only
    logic       tmr1cs;   // [1] 0 = instr_tick, 1 = t1cki
    logic       tmr1on;   // [0] timer on
  } t1con_t;

  // Prescaler terminal mask: the increment fires when all mask bits are set.
  function automatic logic [2:0] presc_mask(input t1ckps_e ps);
    case (ps)
      PS_1_1:  presc_mask = 3'd0;
      PS_1_2:  presc_mask = 3'd1;
      PS_1_4:  presc_mask = 3'd3;
      default: presc_mask = 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/tmr1_peripheral_if.sv
// -----------------------------------------------------------------------------
// tmr1_peripheral_if
//   Register-file side of the external peripheral port.
//   addr     : resolved 9-bit file address
//   wr_en    : write strobe (extern_peripherals_wr_en)
//   data_in  : write data
//   data_out : combinational read data (extern_peripherals_out)
//   master = register file, slave = peripheral.
// -----------------------------------------------------------------------------
interface tmr1_peripheral_if;
  import tmr1_peripheral_pkg::*;

  logic [ADDR_W-1:0] addr;
  logic              wr_en;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;

  modport master (output addr, output wr_en, output data_in, input data_out);
  modport slave  (input addr, input wr_en, input data_in, output data_out);
endinterface

// File: rtl/tmr1_peripheral_sync_edge_detect.sv
// -----------------------------------------------------------------------------
// sync_edge_detect
//   Two-flop synchronizer for an asynchronous pin plus a registered
//   rising-edge pulse. All flops reset synchronously to 0.
//   clk   : core clock
//   rst   : synchronous active-high reset
//   din   : asynchronous input pin
//   level : synchronized level (2 clk after the pin)
//   rise  : one-cycle pulse, 3 clk after a pin rising edge
//   A pin that is already high when reset releases produces no pulse: a rise
//   is only reported once the synchronized level has been seen low.
// -----------------------------------------------------------------------------
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  logic meta;
  logic sync;
  logic sync_prev;
  logic valid_1;   // meta holds a real pin sample
  logic valid_2;   // sync holds a real pin sample
  logic armed;     // a genuine low level has been observed since reset

  // NOTE: every flop here is sequential state, so only non-blocking (<=)
  // assignments are used; blocking ones would collapse the synchronizer chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta      <= 1'b0;
      sync      <= 1'b0;
      sync_prev <= 1'b0;
      valid_1   <= 1'b0;
      valid_2   <= 1'b0;
      armed     <= 1'b0;
      rise      <= 1'b0;
    end else begin
      meta      <= din;
      sync      <= meta;
      sync_prev <= sync;
      valid_1   <= 1'b1;
      valid_2   <= valid_1;
      armed     <= armed | (valid_2 & ~sync);
      rise      <= sync & ~sync_prev & armed;
    end
  end

  assign level = sync;

endmodule

// File: rtl/tmr1_peripheral.sv
// -----------------------------------------------------------------------------
// tmr1_peripheral
//   Timer1 register set (TMR1L, TMR1H, T1CON) behind the core's external
//   peripheral port, plus the 16-bit timer with prescaler and overflow pulse.
//
//   Ports
//     clk           : core clock
//     rst           : synchronous active-high reset
//     bus           : tmr1_peripheral_if.slave (addr, wr_en, data_in, data_out)
//     instr_tick    : internal count source, one pulse per instruction cycle
//     t1cki         : asynchronous external clock pin
//     t1g_n         : asynchronous gate pin (only with TMR1_GATE_EN)
//     tmr1_overflow : one-cycle pulse coinciding with TMR1 = 0 after a wrap
//
//   Configuration macro
//     TMR1_GATE_EN : enables T1CON[7:6] and the t1g_n count gate. Without it
//                    T1CON[7:6] read 0 and t1g_n is ignored.
// -----------------------------------------------------------------------------
module tmr1_peripheral
  import tmr1_peripheral_pkg::*;
#(
  parameter logic [ADDR_W-1:0] TMR1L_ADDR = TMR1L_ADDR_DEF,
  parameter logic [ADDR_W-1:0] TMR1H_ADDR = TMR1H_ADDR_DEF,
  parameter logic [ADDR_W-1:0] T1CON_ADDR = T1CON_ADDR_DEF
) (
  input  logic               clk,
  input  logic               rst,
  tmr1_peripheral_if.slave   bus,
  input  logic               instr_tick,
  input  logic               t1cki,
  input  logic               t1g_n,
  output logic               tmr1_overflow
);

  t1con_t      t1con;
  logic [15:0] tmr1;
  logic [2:0]  presc;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic sel_l, sel_h, sel_c;
  logic wr_l, wr_h, wr_c, tmr_wr;

  assign sel_l  = (bus.addr == TMR1L_ADDR);
  assign sel_h  = (bus.addr == TMR1H_ADDR);
  assign sel_c  = (bus.addr == T1CON_ADDR);
  assign wr_l   = bus.wr_en & sel_l;
  assign wr_h   = bus.wr_en & sel_h;
  assign wr_c   = bus.wr_en & sel_c;
  assign tmr_wr = wr_l | wr_h;

  // ---------------------------------------------------------------------------
  // Count source and gate
  // ---------------------------------------------------------------------------
  logic t1cki_rise;
  logic t1cki_level_unused;
  logic gate_ok;

  sync_edge_detect u_t1cki_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (t1cki),
    .level (t1cki_level_unused),
    .rise  (t1cki_rise)
  );

`ifdef TMR1_GATE_EN
  localparam logic [DATA_W-1:0] T1CON_WR_MASK = 8'hFF;

  logic t1g_sync;
  logic t1g_rise_unused;

  sync_edge_detect u_t1g_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (t1g_n),
    .level (t1g_sync),
    .rise  (t1g_rise_unused)
  );

  // T1GINV=0: count while the pin is low; T1GINV=1: count while it is high.
  assign gate_ok = ~t1con.tmr1ge | (t1g_sync ^ ~t1con.t1ginv);
`else
  localparam logic [DATA_W-1:0] T1CON_WR_MASK = 8'h3F;

  logic t1g_n_unused;
  assign t1g_n_unused = t1g_n;
  assign gate_ok      = 1'b1;
`endif

  logic       src_pulse;
  logic       cnt_en;
  logic [2:0] mask;
  logic       presc_full;
  logic       timer_inc;
  logic       inc_fire;

  assign src_pulse  = t1con.tmr1cs ? t1cki_rise : instr_tick;
  assign cnt_en     = t1con.tmr1on & gate_ok;
  assign mask       = presc_mask(t1con.t1ckps);
  assign presc_full = ((presc & mask) == mask);
  assign timer_inc  = src_pulse & cnt_en & presc_full;
  // A TMR1L/TMR1H write in the same cycle takes precedence over the increment.
  assign inc_fire   = timer_inc & ~tmr_wr;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      t1con         <= '0;
      tmr1          <= 16'h0000;
      presc         <= 3'd0;
      tmr1_overflow <= 1'b0;
    end else begin
      // Registered so the pulse coincides with TMR1 reading 0.
      tmr1_overflow <= inc_fire & (tmr1 == 16'hFFFF);

      if (tmr_wr) begin
        presc <= 3'd0;
      end else if (src_pulse & cnt_en) begin
        presc <= presc_full ? 3'd0 : presc + 3'd1;
      end

      if (inc_fire) begin
        tmr1 <= tmr1 + 16'd1;
      end else begin
        if (wr_l) tmr1[7:0]  <= bus.data_in;
        if (wr_h) tmr1[15:8] <= bus.data_in;
      end

      // The prescaler and increment above use the pre-write T1CON.
      if (wr_c) t1con <= t1con_t'(bus.data_in & T1CON_WR_MASK);
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux (combinational, sampled by the register file)
  // ---------------------------------------------------------------------------
  // NOTE: data_out gets a default before the decode so every path assigns it
  // and no latch is inferred.
  always_comb begin
    bus.data_out = 8'h00;
    if (sel_l)      bus.data_out = tmr1[7:0];
    else if (sel_h) bus.data_out = tmr1[15:8];
    else if (sel_c) bus.data_out = t1con;
  end

endmodule

// File: tb/tb_tmr1_peripheral.sv
// -----------------------------------------------------------------------------
// tb_tmr1_peripheral
//   Directed bench for tmr1_peripheral with hand-computed expected values.
//   Define TMR1_GATE_EN to exercise the gated build.
// -----------------------------------------------------------------------------
module tb_tmr1_peripheral;

  localparam logic [8:0] A_L   = 9'h00E;
  localparam logic [8:0] A_H   = 9'h00F;
  localparam logic [8:0] A_C   = 9'h010;
  localparam logic [8:0] A_UNM = 9'h011;

  logic clk;
  logic rst;
  logic instr_tick;
  logic t1cki;
  logic t1g_n;
  logic tmr1_overflow;

  int tests_run;
  int tests_failed;
  int ovf_count;
  int ovf_base;

  tmr1_peripheral_if bus ();

  tmr1_peripheral dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .instr_tick    (instr_tick),
    .t1cki         (t1cki),
    .t1g_n         (t1g_n),
    .tmr1_overflow (tmr1_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count overflow pulses away from the active edge.
  initial ovf_count = 0;
  always @(negedge clk) if (tmr1_overflow === 1'b1) ovf_count++;

  task automatic check(input string tag, input logic [15:0] actual,
                       input logic [15:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic bus_write(input logic [8:0] a, input logic [7:0] d,
                           input logic with_tick);
    @(negedge clk);
    bus.addr    = a;
    bus.data_in = d;
    bus.wr_en   = 1'b1;
    instr_tick  = with_tick;
    @(negedge clk);
    bus.wr_en   = 1'b0;
    instr_tick  = 1'b0;
  endtask

  task automatic bus_read(input logic [8:0] a, output logic [7:0] v);
    @(negedge clk);
    bus.addr = a;
    #1;
    v = bus.data_out;
  endtask

  task automatic check_reg(input string tag, input logic [8:0] a,
                           input logic [7:0] expected);
    logic [7:0] v;
    bus_read(a, v);
    check(tag, {8'h00, v}, {8'h00, expected});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) instr_tick = 1'b1;
      @(negedge clk) instr_tick = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic t1cki_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      t1cki = 1'b1;
      idle(4);
      t1cki = 1'b0;
      idle(4);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    instr_tick   = 1'b0;
    t1cki        = 1'b0;
    t1g_n        = 1'b1;
    bus.addr     = 9'h000;
    bus.wr_en    = 1'b0;
    bus.data_in  = 8'h00;
    idle(3);
    rst = 1'b0;

    // Reset values and unmapped read.
    check("reset_ovf", {15'd0, tmr1_overflow}, 16'd0);
    check_reg("reset_tmr1l", A_L, 8'h00);
    check_reg("reset_tmr1h", A_H, 8'h00);
    check_reg("reset_t1con", A_C, 8'h00);
    check_reg("reset_unmapped", A_UNM, 8'h00);

    // Wrap FFFE -> FFFF -> 0000 with a single overflow pulse.
    bus_write(A_C, 8'h01, 1'b0);
    bus_write(A_H, 8'hFF, 1'b0);
    bus_write(A_L, 8'hFE, 1'b0);
    check_reg("wr_readback_l", A_L, 8'hFE);
    ovf_base = ovf_count;
    ticks(1);
    check("ovf_none_first", 16'(ovf_count - ovf_base), 16'd0);
    check_reg("tick1_l", A_L, 8'hFF);
    check_reg("tick1_h", A_H, 8'hFF);
    ticks(1);
    check("ovf_pulse_level", {15'd0, tmr1_overflow}, 16'd1);
    idle(2);
    check("ovf_one_pulse", 16'(ovf_count - ovf_base), 16'd1);
    check("ovf_dropped", {15'd0, tmr1_overflow}, 16'd0);
    check_reg("wrap_l", A_L, 8'h00);
    check_reg("wrap_h", A_H, 8'h00);

    // 1:8 prescale.
    bus_write(A_C, 8'h31, 1'b0);
    bus_write(A_L, 8'h00, 1'b0);
    ticks(16);
    check_reg("ps8_16ticks", A_L, 8'h02);
    ticks(3);
    bus_write(A_L, 8'h10, 1'b0);
    ticks(7);
    check_reg("ps8_after_wr_7", A_L, 8'h10);
    ticks(1);
    check_reg("ps8_after_wr_8", A_L, 8'h11);
    check_reg("ps8_t1con", A_C, 8'h31);

    // External clock, 1:1.
    bus_write(A_C, 8'h03, 1'b0);
    bus_write(A_L, 8'h00, 1'b0);
    bus_write(A_H, 8'h00, 1'b0);
    t1cki_pulses(5);
    idle(5);
    check_reg("ext_5_pulses", A_L, 8'h05);
    bus_write(A_C, 8'h02, 1'b0);
    t1cki_pulses(5);
    idle(5);
    check_reg("ext_off", A_L, 8'h05);

    // Write vs increment collision, right at the wrap point.
    bus_write(A_C, 8'h01, 1'b0);
    bus_write(A_H, 8'hFF, 1'b0);
    bus_write(A_L, 8'hFF, 1'b0);
    ovf_base = ovf_count;
    bus_write(A_L, 8'h40, 1'b1);
    idle(2);
    check_reg("coll_l", A_L, 8'h40);
    check_reg("coll_h", A_H, 8'hFF);
    check("coll_no_ovf", 16'(ovf_count - ovf_base), 16'd0);
    // T1CON write with a tick: increment uses the old 1:1 setting.
    bus_write(A_C, 8'h31, 1'b1);
    check_reg("t1con_coll_l", A_L, 8'h41);
    check_reg("t1con_coll_c", A_C, 8'h31);

    // T1CON upper-bit masking and unmapped write.
    bus_write(A_C, 8'hFC, 1'b0);
`ifdef TMR1_GATE_EN
    check_reg("t1con_mask", A_C, 8'hFC);
`else
    check_reg("t1con_mask", A_C, 8'h3C);
`endif
    bus_write(A_UNM, 8'h55, 1'b0);
    check_reg("unm_read", A_UNM, 8'h00);
    check_reg("unm_no_effect", A_L, 8'h41);

    // Gate.
    bus_write(A_C, 8'h41, 1'b0);
    bus_write(A_L, 8'h00, 1'b0);
    t1g_n = 1'b1;
    idle(3);
    ticks(10);
`ifdef TMR1_GATE_EN
    check_reg("gate_closed_hi", A_L, 8'h00);
    t1g_n = 1'b0;
    idle(3);
    ticks(10);
    check_reg("gate_open_lo", A_L, 8'h0A);
    bus_write(A_C, 8'hC1, 1'b0);
    bus_write(A_L, 8'h00, 1'b0);
    ticks(10);
    check_reg("ginv_closed_lo", A_L, 8'h00);
    t1g_n = 1'b1;
    idle(3);
    ticks(10);
    check_reg("ginv_open_hi", A_L, 8'h0A);
`else
    check_reg("nogate_t1con", A_C, 8'h01);
    check_reg("nogate_count", A_L, 8'h0A);
`endif

    // Reset coinciding with a wrapping increment: no overflow survives.
    bus_write(A_C, 8'h01, 1'b0);
    bus_write(A_H, 8'hFF, 1'b0);
    bus_write(A_L, 8'hFF, 1'b0);
    ovf_base = ovf_count;
    @(negedge clk);
    instr_tick = 1'b1;
    rst        = 1'b1;
    @(negedge clk);
    instr_tick = 1'b0;
    rst        = 1'b0;
    check("rst_ovf_level", {15'd0, tmr1_overflow}, 16'd0);
    check_reg("rst_mid_l", A_L, 8'h00);
    check_reg("rst_mid_h", A_H, 8'h00);
    check_reg("rst_mid_c", A_C, 8'h00);
    check("rst_ovf_count", 16'(ovf_count - ovf_base), 16'd0);

    // t1cki already high across reset must not count.
    t1cki = 1'b1;
    rst   = 1'b1;
    idle(2);
    rst = 1'b0;
    bus_write(A_C, 8'h03, 1'b0);
    idle(8);
    check_reg("t1cki_high_at_rst", A_L, 8'h00);
    t1cki = 1'b0;
    idle(4);
    t1cki = 1'b1;
    idle(6);
    check_reg("t1cki_first_real_edge", A_L, 8'h01);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
